// File: rtl/clk_gate_pkg.sv
// Shared definitions for the idle-detect clock-gate controller.
package clk_gate_pkg;

  localparam int GATE_EV_W = 16;

  typedef enum logic [1:0] {
    CG_RUN   = 2'b00,
    CG_GATED = 2'b01,
    CG_WAKE  = 2'b10
  } cg_state_e;

  // Saturating increment for the gate-event counter; holds at all-ones.
  function automatic logic [GATE_EV_W-1:0] sat_inc(input logic [GATE_EV_W-1:0] v);
    return (&v) ? v : v + GATE_EV_W'(1);
  endfunction

endpackage

// File: rtl/clk_gate_ctl.sv
// Idle-detect enable generator for the com1a phi1 clock gater. Runs on the
// ungated clock; drops condition after IDLE_CYCLES idle cycles and restores
// it on a wake, acknowledging once the settle window has elapsed.
module clk_gate_ctl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = $clog2(IDLE_CYCLES + WAKE_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 gate_en,
  input  logic                 busy,
  input  logic                 wake_req,
  output logic                 condition,
  output logic                 gated,
  output logic                 wake_ack,
  output logic [GATE_EV_W-1:0] gate_events
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  cg_state_e             r_state;
  cg_state_e             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_condition;
  logic                  r_gated;
  logic                  r_wake_ack;
  logic                  w_ack_nxt;
  logic [GATE_EV_W-1:0]  r_gate_events;
  logic [GATE_EV_W-1:0]  w_ev_nxt;
  logic                  w_idle;
  logic                  w_wake_cond;

  assign w_idle      = gate_en & ~busy & ~wake_req;
  assign w_wake_cond = wake_req | busy | ~gate_en;

  // State and shared idle/wake counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CG_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and event logic; one counter serves both RUN and WAKE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_ev_nxt    = r_gate_events;
    case (r_state)
      CG_RUN: begin
        if (w_idle) begin
          if (r_cnt == IDLE_LAST) begin
            w_state_nxt = CG_GATED;
            w_cnt_nxt   = '0;
            w_ev_nxt    = sat_inc(r_gate_events);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      CG_GATED: begin
        w_cnt_nxt = '0;
        if (w_wake_cond) w_state_nxt = CG_WAKE;
      end
      CG_WAKE: begin
        // Inputs are ignored here so the settle window is never shortened.
        if (r_cnt == WAKE_LAST) begin
          w_state_nxt = CG_RUN;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = CG_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered outputs so condition is glitch-free; reset ungates at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_condition   <= 1'b1;
      r_gated       <= 1'b0;
      r_wake_ack    <= 1'b0;
      r_gate_events <= '0;
    end else begin
      r_condition   <= (w_state_nxt != CG_GATED);
      r_gated       <= (w_state_nxt == CG_GATED);
      r_wake_ack    <= w_ack_nxt;
      r_gate_events <= w_ev_nxt;
    end
  end

  assign condition   = r_condition;
  assign gated       = r_gated;
  assign wake_ack    = r_wake_ack;
  assign gate_events = r_gate_events;

endmodule
